stack_mem_responder: RTL and testbench
======================================

// Module: stack_mem_responder
// PURPOSE
// Responder end of the calculator-controller <-> stack-memory interface. Serves single-word
// reads/writes issued by the stack controller over a req/ready handshake, returns read data
// with a registered valid strobe and bus-drive enable for the shared 8-bit data bus, and
// performs a full-array clear sweep on reset or on command. Sits beside the controller in
// the top level; the top gates rdata onto data_bus with bus_oe.
// PARAMETERS
//   ADDR_W     7      address width; DEPTH is fixed at 2**ADDR_W (128 words)
//   DATA_W     8      word width
//   CLEAR_VAL  8'h00  value written to every word by the clear sweep
// PORTS
//   clk       in   1       system clock, all logic on posedge
//   rst       in   1       synchronous, active-high reset
//   req       in   1       request valid; accepted only on posedge with req && ready
//   we        in   1       1 = write, 0 = read; sampled with req
//   addr      in   ADDR_W  word address; sampled with req
//   wdata     in   DATA_W  write data; sampled with req && we
//   clr       in   1       start clear sweep; sampled only when ready
//   ready     out  1       responder can accept req/clr this cycle
//   rvalid    out  1       one-cycle strobe: rdata holds read result
//   rdata     out  DATA_W  read data; holds last value between reads
//   bus_oe    out  1       top drives rdata onto data_bus; equals rvalid
//   req_drop  out  1       one-cycle pulse: req discarded because clr won
// BEHAVIOUR
// - States: CLEAR, IDLE, RESP. Reset: state=CLEAR, clear ptr=0, ready=0, rvalid=0, bus_oe=0,
//   rdata=0, req_drop=0. rst asserted at any time (mid-sweep, mid-RESP) restarts from here.
// - CLEAR: ready=0; each cycle mem[ptr]<=CLEAR_VAL, ptr++. After ptr=DEPTH-1 is written
//   -> IDLE; ready rises exactly DEPTH (128) cycles after the first cycle with rst low.
//   req/clr ignored throughout.
// - IDLE: ready=1.
//   * clr=1 -> CLEAR (ptr=0). If req also =1 that cycle: request is NOT executed,
//     req_drop=1 for one cycle. clr has strict priority.
//   * req&&we -> mem[addr]<=wdata on that edge; stay IDLE; no response; ready stays 1
//     (back-to-back writes at 1/cycle).
//   * req&&!we -> capture addr, -> RESP.
// - RESP: one cycle; ready=0, rvalid=1, bus_oe=1, rdata=mem[captured addr]. -> IDLE.
//   Read latency: accept at edge N, data valid during cycle N+1; reads sustain 1 per 2 cycles.
// - req while ready=0: no effect; controller holds req/we/addr/wdata until accepted.
// - Read-after-write: write accepted at edge N, read of same addr accepted at N+1 returns new
//   data (no stale value). Single port: at most one access per cycle, no same-cycle RAW.
// - Addressing: full ADDR_W decode, no out-of-range case; no wrap logic beyond clear ptr,
//   which stops at DEPTH-1 (never wraps to 0 while in CLEAR).
// - All outputs registered; no combinational path from inputs to outputs.
// STRUCTURE
// - Shared header stack_mem_defs.vh: ADDR_W, DATA_W, DEPTH, CLEAR_VAL, state codes
//   ST_CLEAR=2'd0, ST_IDLE=2'd1, ST_RESP=2'd2; also used by the controller.
// - One sub-module: ram_sp (single-port, sync write, sync read, DEPTH x DATA_W); write port
//   muxed between sweep (ptr, CLEAR_VAL) and request (addr, wdata). FSM, ptr and output
//   registers live in stack_mem_responder.
// TESTING
// 1 rst high 2 cycles then low -> ready=0 for 128 cycles then 1; read 7'h7F -> rvalid next
//   cycle, rdata=8'h00, bus_oe=1 for exactly 1 cycle.
// 2 write 7'h7F=8'h05, write 7'h7E=8'h03 back-to-back, read 7'h7E -> rdata=8'h03; read
//   7'h7F -> 8'h05; ready=0 only in each RESP cycle.
// 3 write 7'h10=8'hA5 then read 7'h10 on the very next edge -> rdata=8'hA5 (no stale data).
// 4 write 7'h01=8'h11; then clr=1 with req write 7'h02=8'h22 same cycle -> req_drop pulse,
//   ready low 128 cycles; reads of 7'h01 and 7'h02 -> 8'h00.
// 5 rst asserted at sweep cycle 50, held 1 cycle -> sweep restarts at 0; ready rises 128
//   cycles after rst falls; rst during RESP -> rvalid/bus_oe drop next cycle.
// 6 req held high through RESP for 3 queued reads -> exactly 3 rvalid strobes, each with
//   the correct word; rvalid never asserted in CLEAR.

Source files
------------

// File: rtl/stack_mem_responder_pkg.sv
// Shared constants for the stack-memory responder and the stack controller that talks to it.
package stack_mem_responder_pkg;

  // Geometry of the stack memory: 128 words of 8 bits.
  localparam int          SM_ADDR_W    = 7;
  localparam int          SM_DATA_W    = 8;
  localparam int          SM_DEPTH     = 1 << SM_ADDR_W;
  localparam logic [7:0]  SM_CLEAR_VAL = 8'h00;

  // Responder state codes, shared with the controller so both sides decode the same values.
  typedef logic [1:0] state_t;
  localparam state_t ST_CLEAR = 2'd0;
  localparam state_t ST_IDLE  = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/stack_mem_responder_ram_sp.sv
// Single-port RAM with synchronous write and registered synchronous read.
// The read register only loads on a read, so it holds the last word read in between.
module ram_sp #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  // Storage array: written by the clear sweep or by an accepted write request.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: cleared on reset so the responder's read data starts at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_mem_responder.sv
// Responder end of the controller <-> stack-memory link: serves single-word reads and
// writes over a req/ready handshake and clears the whole array on reset or on command.
module stack_mem_responder
  import stack_mem_responder_pkg::*;
#(
  parameter int                ADDR_W    = SM_ADDR_W,
  parameter int                DATA_W    = SM_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = SM_CLEAR_VAL
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bus_oe,
  output logic              o_req_drop
);

  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_clrPtr;
  logic              r_ready;
  logic              r_rvalid;
  logic              r_busOe;
  logic              r_reqDrop;

  logic              w_ramWe;
  logic              w_ramRe;
  logic [ADDR_W-1:0] w_ramAddr;
  logic [DATA_W-1:0] w_ramWdata;
  logic [DATA_W-1:0] w_ramRdata;

  // RAM port mux: the sweep owns the port in CLEAR; otherwise an accepted request does,
  // unless clr wins the cycle, in which case the request is dropped untouched.
  always_comb begin
    w_ramWe    = 1'b0;
    w_ramRe    = 1'b0;
    w_ramAddr  = i_addr;
    w_ramWdata = i_wdata;
    if (!i_rst) begin
      if (r_state == ST_CLEAR) begin
        w_ramWe    = 1'b1;
        w_ramAddr  = r_clrPtr;
        w_ramWdata = CLEAR_VAL;
      end else if (r_state == ST_IDLE && i_req && !i_clr) begin
        w_ramWe = i_we;
        w_ramRe = !i_we;
      end
    end
  end

  // Control FSM: sweep, accept requests, and produce the one-cycle read response strobes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_CLEAR;
      r_clrPtr  <= '0;
      r_ready   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_busOe   <= 1'b0;
      r_reqDrop <= 1'b0;
    end else begin
      r_rvalid  <= 1'b0;
      r_busOe   <= 1'b0;
      r_reqDrop <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_clrPtr == PTR_LAST) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_clrPtr <= r_clrPtr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (i_clr) begin
            r_state   <= ST_CLEAR;
            r_clrPtr  <= '0;
            r_ready   <= 1'b0;
            r_reqDrop <= i_req;
          end else if (i_req && !i_we) begin
            r_state  <= ST_RESP;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b1;
            r_busOe  <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state  <= ST_CLEAR;
          r_clrPtr <= '0;
          r_ready  <= 1'b0;
        end
      endcase
    end
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_ramWe),
    .i_re    (w_ramRe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_ramWdata),
    .o_rdata (w_ramRdata)
  );

  assign o_ready    = r_ready;
  assign o_rvalid   = r_rvalid;
  assign o_bus_oe   = r_busOe;
  assign o_req_drop = r_reqDrop;
  assign o_rdata    = w_ramRdata;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder: directed scenarios plus random traffic
// checked against a plain array model of the 128-word memory.
module tb_stack_mem_responder;

  logic       clk;
  logic       rst;
  logic       req;
  logic       we;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       clr;
  logic       ready;
  logic       rvalid;
  logic [7:0] rdata;
  logic       busOe;
  logic       reqDrop;

  logic [7:0] model [0:127];
  int compared;
  int mismatched;

  stack_mem_responder dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_we       (we),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_clr      (clr),
    .o_ready    (ready),
    .o_rvalid   (rvalid),
    .o_rdata    (rdata),
    .o_bus_oe   (busOe),
    .o_req_drop (reqDrop)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a stuck design still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [6:0] a,
                               input logic [7:0] d, input logic c);
    req   = r;
    we    = w;
    addr  = a;
    wdata = d;
    clr   = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
  endtask

  // Counts cycles until ready rises, checking no read strobe appears while sweeping.
  task automatic waitReady(input string tag, input int startCount, input int expCycles);
    int  cnt;
    bit  sawValid;
    cnt      = startCount;
    sawValid = 1'b0;
    while (!ready && cnt < 400) begin
      tick();
      cnt++;
      if (rvalid || busOe) sawValid = 1'b1;
    end
    checkOutput({tag, "_cycles"}, cnt, expCycles);
    checkOutput({tag, "_no_rvalid"}, 32'(sawValid), 0);
    clearModel();
  endtask

  task automatic writeWord(input logic [6:0] a, input logic [7:0] d);
    applyStimulus(1'b1, 1'b1, a, d, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    model[a] = d;
    checkOutput("write_ready", 32'(ready), 1);
    checkOutput("write_no_rvalid", 32'(rvalid), 0);
  endtask

  task automatic readWord(input logic [6:0] a);
    applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    checkOutput("read_rvalid", 32'(rvalid), 1);
    checkOutput("read_bus_oe", 32'(busOe), 1);
    checkOutput("read_ready_low", 32'(ready), 0);
    checkOutput("read_rdata", 32'(rdata), 32'(model[a]));
    tick();
    checkOutput("read_rvalid_off", 32'(rvalid), 0);
    checkOutput("read_bus_oe_off", 32'(busOe), 0);
    checkOutput("read_ready_back", 32'(ready), 1);
    checkOutput("read_rdata_hold", 32'(rdata), 32'(model[a]));
  endtask

  initial begin
    logic [6:0] q [3];
    logic [6:0] ra;
    int strobes;
    compared   = 0;
    mismatched = 0;
    clearModel();
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);

    // Scenario 1: reset, full sweep, read the top word.
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_ready", 32'(ready), 0);
    checkOutput("reset_rvalid", 32'(rvalid), 0);
    checkOutput("reset_bus_oe", 32'(busOe), 0);
    checkOutput("reset_rdata", 32'(rdata), 0);
    checkOutput("reset_req_drop", 32'(reqDrop), 0);
    rst = 1'b0;
    waitReady("sweep_after_reset", 0, 128);
    readWord(7'h7F);

    // Scenario 2: back-to-back writes then reads.
    writeWord(7'h7F, 8'h05);
    writeWord(7'h7E, 8'h03);
    readWord(7'h7E);
    readWord(7'h7F);

    // Scenario 3: read on the edge right after a write to the same address.
    writeWord(7'h10, 8'hA5);
    readWord(7'h10);

    // Scenario 4: clr beats a simultaneous write, then the whole array reads back clear.
    writeWord(7'h01, 8'h11);
    applyStimulus(1'b1, 1'b1, 7'h02, 8'h22, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    checkOutput("clr_req_drop", 32'(reqDrop), 1);
    checkOutput("clr_ready_low", 32'(ready), 0);
    tick();
    checkOutput("clr_req_drop_pulse", 32'(reqDrop), 0);
    waitReady("sweep_after_clr", 1, 128);
    readWord(7'h01);
    readWord(7'h02);

    // Scenario 5: reset mid-sweep restarts the sweep; reset during a response kills it.
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    for (int i = 1; i < 50; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midsweep_reset_ready", 32'(ready), 0);
    waitReady("sweep_after_midsweep_reset", 0, 128);
    writeWord(7'h33, 8'h5A);
    applyStimulus(1'b1, 1'b0, 7'h33, 8'h00, 1'b0);
    tick();
    checkOutput("resp_before_reset_rvalid", 32'(rvalid), 1);
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("resp_reset_rvalid", 32'(rvalid), 0);
    checkOutput("resp_reset_bus_oe", 32'(busOe), 0);
    checkOutput("resp_reset_rdata", 32'(rdata), 0);
    waitReady("sweep_after_resp_reset", 0, 128);

    // Scenario 6: req held high across responses for three queued reads.
    for (int i = 0; i < 3; i++) begin
      q[i] = 7'(8'h40 + 8'(i * 5));
      writeWord(q[i], 8'($urandom));
    end
    strobes = 0;
    applyStimulus(1'b1, 1'b0, q[0], 8'h00, 1'b0);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (rvalid) begin
        if (strobes < 3) checkOutput("queued_rdata", 32'(rdata), 32'(model[q[strobes]]));
        strobes++;
        if (strobes < 3) addr = q[strobes];
        else req = 1'b0;
      end
    end
    applyStimulus(1'b0, 1'b0, 7'h00, 8'h00, 1'b0);
    checkOutput("queued_strobes", 32'(strobes), 3);

    // Random traffic against the array model.
    for (int n = 0; n < 60; n++) begin
      ra = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) writeWord(ra, 8'($urandom));
      else readWord(ra);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
